// File: rtl/div_display_pkg.sv
// Shared types and helpers for the divider result display: FSM states, digit codes, segment decode.
package div_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        LOAD   = 2'd3
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t     DIG_BLANK = 4'hA;
    localparam digit_t     DIG_DASH  = 4'hB;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Segment order {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] seg_decode(input digit_t code);
        case (code)
            4'd0:     seg_decode = 7'b1000000;
            4'd1:     seg_decode = 7'b1111001;
            4'd2:     seg_decode = 7'b0100100;
            4'd3:     seg_decode = 7'b0110000;
            4'd4:     seg_decode = 7'b0011001;
            4'd5:     seg_decode = 7'b0010010;
            4'd6:     seg_decode = 7'b0000010;
            4'd7:     seg_decode = 7'b1111000;
            4'd8:     seg_decode = 7'b0000000;
            4'd9:     seg_decode = 7'b0010000;
            DIG_DASH: seg_decode = SEG_DASH;
            default:  seg_decode = SEG_BLANK;
        endcase
    endfunction

    // Turns a 3-digit BCD value into the {tens, ones} pair shown on the display.
    function automatic logic [7:0] field_digits(input logic [11:0] bcd, input logic blank_lead);
        if (bcd[11:8] != 4'd0)
            field_digits = {DIG_DASH, DIG_DASH};
        else if (blank_lead && bcd[7:4] == 4'd0)
            field_digits = {DIG_BLANK, bcd[3:0]};
        else
            field_digits = bcd[7:0];
    endfunction

endpackage

// File: rtl/div_result_display_bin2bcd.sv
// Iterative 7-bit double dabble: load performs the first shift, six more cycles complete it.
// done stays high once the result is ready, until the next load.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [6:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [6:0] sh;
    logic [2:0] cnt;

    function automatic logic [11:0] dabble_step(input logic [11:0] b, input logic in_bit);
        logic [11:0] a;
        for (int i = 0; i < 3; i++) begin
            a[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return {a[10:0], in_bit};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd <= '0;
            sh  <= '0;
            cnt <= 3'd7;
        end else if (load) begin
            // First shift from an all-zero BCD needs no add-3 correction.
            bcd <= {11'd0, bin[6]};
            sh  <= {bin[5:0], 1'b0};
            cnt <= 3'd1;
        end else if (cnt != 3'd7) begin
            bcd <= dabble_step(bcd, sh[6]);
            sh  <= {sh[5:0], 1'b0};
            cnt <= cnt + 3'd1;
        end
    end

    assign done = (cnt == 3'd7);

endmodule

// File: rtl/div_result_display.sv
// Captures divider Q/R, converts to BCD and scans them onto a 4-digit 7-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit per field.
module div_result_display
    import div_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] q,
    input  logic [6:0] r,
    output logic       busy,
    output logic       ready,
    output logic [3:0] anodo,
    output logic [6:0] seven
);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic BLANK_LEAD = 1'b1;
`else
    localparam logic BLANK_LEAD = 1'b0;
`endif

    state_t       state, state_nxt;
    logic [6:0]   r_lat;
    logic [11:0]  q_bcd;
    logic         eng_load, eng_done;
    logic [6:0]   eng_bin;
    logic [11:0]  eng_bcd;
    logic         dig_we;
    digit_t [3:0] dig, dig_nxt;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]   sel, sel_nxt;
    logic         wrap;

    bin2bcd_seq u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .load (eng_load),
        .bin  (eng_bin),
        .done (eng_done),
        .bcd  (eng_bcd)
    );

    // The converter is shared: Q is loaded on start, R as soon as Q finishes.
    always_comb begin
        state_nxt = state;
        eng_load  = 1'b0;
        eng_bin   = q;
        dig_we    = 1'b0;
        case (state)
            IDLE: if (start) begin
                eng_load  = 1'b1;
                state_nxt = CONV_Q;
            end
            CONV_Q: if (eng_done) begin
                eng_load  = 1'b1;
                eng_bin   = r_lat;
                state_nxt = CONV_R;
            end
            CONV_R: if (eng_done) state_nxt = LOAD;
            LOAD: begin
                dig_we    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r_lat <= '0;
            q_bcd <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= dig_we;
            if (state == IDLE && start)
                r_lat <= r;
            if (state == CONV_Q && eng_done)
                q_bcd <= eng_bcd;
        end
    end

    assign busy = (state != IDLE);

    // R is still sitting in the converter during LOAD.
    always_comb begin
        dig_nxt = dig;
        if (dig_we)
            dig_nxt = {field_digits(q_bcd, BLANK_LEAD), field_digits(eng_bcd, BLANK_LEAD)};
    end

    assign wrap    = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    assign sel_nxt = wrap ? sel + 2'd1 : sel;

    // anodo and seven are built from next-cycle values so they change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            sel         <= 2'd0;
            anodo       <= 4'b1110;
            seven       <= SEG_BLANK;
            dig         <= {4{DIG_BLANK}};
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + CNT_W'(1);
            sel         <= sel_nxt;
            anodo       <= ~(4'b0001 << sel_nxt);
            seven       <= seg_decode(dig_nxt[sel_nxt]);
            dig         <= dig_nxt;
        end
    end

endmodule
